key_scan_ctrl: RTL
==================

KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

Interface
REQ-001 Parameter N_KEYS, default 4, number of mechanical keys sharing one debounce counter.
REQ-002 Parameter DEBOUNCE_CYC, default 20, consecutive cycles a changed level must hold before commit; legal range 2..2^20-1.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 key  input  N_KEYS  raw asynchronous key levels; 0 = pressed, 1 = released.
REQ-006 evt_valid  output  1  debounced event available.
REQ-007 evt_ready  input  1  consumer accepts event when high together with evt_valid.
REQ-008 evt_key  output  clog2(N_KEYS)  index of the key that produced the event.
REQ-009 evt_press  output  1  1 = press (released to pressed), 0 = release.
REQ-010 key_state  output  N_KEYS  committed debounced level per key.
REQ-011 busy  output  1  high in COUNT or EMIT.

Function
REQ-012 Each key bit SHALL pass a 2-flop synchronizer before any use; "synced level" below means its output.
REQ-013 A round-robin pointer ptr (0..N_KEYS-1) SHALL select the key owning the single shared 20-bit counter.
REQ-014 FSM states SHALL be SCAN, COUNT and EMIT.
REQ-015 SCAN: if synced[ptr] equals key_state[ptr], ptr advances by 1 (wrapping N_KEYS-1 to 0) and the FSM stays in SCAN; otherwise cnt is cleared and the FSM enters COUNT with ptr held.
REQ-016 COUNT: if synced[ptr] equals key_state[ptr], the attempt aborts: cnt cleared, ptr advances, next state SCAN, no event.
REQ-017 COUNT: otherwise, if cnt equals DEBOUNCE_CYC-1, the block commits: key_state[ptr] takes synced[ptr], evt_key takes ptr, evt_press takes the inverse of the new level, and next state is EMIT; otherwise cnt increments.
REQ-018 Latency: SCAN detecting a difference at cycle t SHALL give evt_valid high at cycle t+DEBOUNCE_CYC+1 when the level holds.
REQ-019 EMIT: evt_valid SHALL be high, with evt_key and evt_press stable; when evt_ready is high, next state is SCAN, ptr advances and evt_valid falls.
REQ-020 Backpressure: while in EMIT with evt_ready low, no other key is scanned or counted; key changes during the stall are caught on later scans.
REQ-021 Multiple simultaneous changes SHALL be serviced one at a time, in increasing index order starting from ptr, wrapping around.
REQ-022 A key that bounces back during COUNT and changes again SHALL restart from cnt=0 on its next SCAN visit.
REQ-023 The counter SHALL never exceed DEBOUNCE_CYC-1 and SHALL be 0 whenever the state is not COUNT.
REQ-024 An illegal state encoding SHALL recover to SCAN with cnt=0 and evt_valid=0.

Reset
REQ-025 On rst_n low, the following SHALL hold asynchronously: state=SCAN, ptr=0, cnt=0, evt_valid=0, evt_key=0, evt_press=0, key_state all 1, synchronizer flops all 1, busy=0.
REQ-026 Reset asserted mid-COUNT or mid-EMIT SHALL discard the pending attempt or event; no event is emitted after release.

Structure
REQ-027 Package key_pkg SHALL hold the FSM state type (SCAN/COUNT/EMIT), the N_KEYS and DEBOUNCE_CYC defaults, and the counter width of 20.
REQ-028 Sub-module key_sync SHALL implement the parameterized-width 2-flop synchronizer with reset value 1; everything else stays in key_scan_ctrl.

Verification (N_KEYS=4, DEBOUNCE_CYC=20, evt_ready=1 unless stated)
REQ-029 Clean press: key[2] goes 1 to 0 and holds. Required: exactly one event, evt_key=2, evt_press=1; key_state=4'b1011; evt_valid exactly 21 cycles after the SCAN visit of key 2.
REQ-030 Bounce: key[1] low for 10 cycles, then high. Required: no event, key_state unchanged, busy returns to 0.
REQ-031 Simultaneous press: key[0] and key[3] go low in the same cycle with ptr=1. Required: key 3 event first, then key 0 event, each pulse one handshake long.
REQ-032 Backpressure: evt_ready=0 for 50 cycles after a key 0 press while key 1 is pressed. Required: evt_valid, evt_key=0 and evt_press=1 held stable; key 1 event only after the handshake.
REQ-033 Release and wrap: press then release key 3. Required: press event, then release event (evt_press=0); ptr wraps 3 to 0; key_state returns to 4'b1111.
REQ-034 Reset mid-COUNT: pulse rst_n low at cnt=15 while key 0 is held low. Required: no event during reset; all outputs at reset values; one key 0 press event after the full 20-cycle recount.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and defaults for the key scan / debounce controller.
package key_pkg;

    localparam int N_KEYS_DEF       = 4;
    localparam int DEBOUNCE_CYC_DEF = 20;
    localparam int CNT_W            = 20;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        COUNT = 2'd1,
        EMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for raw key levels; resets to 1 (released).
module key_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments keep the two stages as separate flops;
    // blocking would collapse them into one and defeat the synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_scan_ctrl.sv
// Round-robin key scanner sharing one debounce counter across all keys,
// emitting one press/release event at a time over a valid/ready handshake.
module key_scan_ctrl
    import key_pkg::*;
#(
    parameter int N_KEYS       = N_KEYS_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    localparam int PTR_W       = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [PTR_W-1:0]  evt_key,
    output logic              evt_press,
    output logic [N_KEYS-1:0] key_state,
    output logic              busy
);

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  next_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [N_KEYS-1:0] synced;
    logic              level_same;

    key_sync #(.WIDTH(N_KEYS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key),
        .q     (synced)
    );

    assign next_ptr   = (ptr == PTR_W'(N_KEYS - 1)) ? '0 : ptr + PTR_W'(1);
    assign level_same = (synced[ptr] == key_state[ptr]);
    assign busy       = (state == COUNT) || (state == EMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            ptr       <= '0;
            cnt       <= '0;
            evt_valid <= 1'b0;
            evt_key   <= '0;
            evt_press <= 1'b0;
            key_state <= '1;
        end else begin
            case (state)
                SCAN: begin
                    if (level_same) begin
                        ptr <= next_ptr;
                    end else begin
                        cnt   <= '0;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (level_same) begin
                        // Bounced back before the hold time: drop the attempt.
                        cnt   <= '0;
                        ptr   <= next_ptr;
                        state <= SCAN;
                    end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                        key_state[ptr] <= synced[ptr];
                        evt_key        <= ptr;
                        evt_press      <= ~synced[ptr];
                        evt_valid      <= 1'b1;
                        cnt            <= '0;
                        state          <= EMIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                EMIT: begin
                    // Scanning stalls here until the consumer takes the event.
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        ptr       <= next_ptr;
                        state     <= SCAN;
                    end
                end
                default: begin
                    state     <= SCAN;
                    cnt       <= '0;
                    evt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
